// File: rtl/param_rom_pkg.sv
// ----------------------------------------------------------------------------
// param_rom_pkg
//   Shared types and constants for the parameter-ROM streaming controller.
//   - state_t          : controller FSM states
//   - DEF_ROM_LATENCY  : default ROM read latency (cycles, ce held high)
// ----------------------------------------------------------------------------
package param_rom_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      DRAIN = 2'd2,
      FIN   = 2'd3
   } state_t;

   localparam int DEF_ROM_LATENCY = 2;

endpackage

// File: rtl/param_rom_skid_fifo.sv
// ----------------------------------------------------------------------------
// param_rom_skid_fifo
//   Small show-ahead FIFO that absorbs ROM words already in flight when the
//   downstream consumer stalls. The head word is presented combinationally on
//   rdata whenever empty is low. DEPTH need not be a power of two.
//
// Parameters
//   WIDTH : word width in bits
//   DEPTH : number of entries (>= 2)
// Ports
//   clk, rst        : clock, asynchronous active-low reset (clears pointers)
//   push, wdata     : write strobe and data
//   pop             : advance the head (only when not empty)
//   rdata           : head word
//   full, empty     : status flags
//   count           : current occupancy
// ----------------------------------------------------------------------------
module param_rom_skid_fifo
   import param_rom_pkg::*;
#(
   parameter  int WIDTH = 8,
   parameter  int DEPTH = 3,
   localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] wdata,
   input  logic             pop,
   output logic [WIDTH-1:0] rdata,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PW-1:0]    wr_ptr;
   logic [PW-1:0]    rd_ptr;

   // Pointers wrap explicitly so non power-of-two depths work.
   function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
      return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
   endfunction

   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= ptr_inc(wr_ptr);
         if (pop)  rd_ptr <= ptr_inc(rd_ptr);
         count <= count + CW'(push) - CW'(pop);
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CW'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/param_rom_stream_ctrl.sv
// ----------------------------------------------------------------------------
// param_rom_stream_ctrl
//   Streams the contents of a fixed-latency ROM (addresses 0..DEPTH-1,
//   repeated num_passes times) onto a valid/ready stream at up to one word
//   per cycle. Reads are credit-limited so every word in flight always has a
//   slot in the skid FIFO, which lets the consumer stall at any time without
//   loss.
//
// Parameters
//   DATA_WIDTH, DEPTH, ADDR_WIDTH, ROM_LATENCY, PASS_WIDTH
// Ports
//   clk, rst               : clock, asynchronous active-low reset
//   start, num_passes      : one-cycle request and pass count (IDLE only)
//   busy, done            : activity flag, one-cycle completion pulse
//   rom_addr, rom_ce, rom_q: ROM read port (ce tied high)
//   data_out, data_out_valid, data_out_ready : output stream
//   stall_count            : (PARAM_ROM_STREAM_CTRL_PERF_EN only) saturating
//                            count of cycles with valid & !ready
//
// Build option: define PARAM_ROM_STREAM_CTRL_PERF_EN to add stall_count.
// ----------------------------------------------------------------------------
module param_rom_stream_ctrl
   import param_rom_pkg::*;
#(
   parameter int DATA_WIDTH  = 128,
   parameter int DEPTH       = 576,
   parameter int ADDR_WIDTH  = $clog2(DEPTH) + 1,
   parameter int ROM_LATENCY = DEF_ROM_LATENCY,
   parameter int PASS_WIDTH  = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [PASS_WIDTH-1:0] num_passes,
   output logic                  busy,
   output logic                  done,
   output logic [ADDR_WIDTH-1:0] rom_addr,
   output logic                  rom_ce,
   input  logic [DATA_WIDTH-1:0] rom_q,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic                  data_out_valid,
   input  logic                  data_out_ready
`ifdef PARAM_ROM_STREAM_CTRL_PERF_EN
   ,
   output logic [31:0]           stall_count
`endif
);

   localparam int FIFO_DEPTH = ROM_LATENCY + 1;
   localparam int CW         = $clog2(FIFO_DEPTH + 1);

   state_t                  state, state_n;
   logic [ADDR_WIDTH-1:0]   addr;
   logic [PASS_WIDTH-1:0]   pass_cnt;
   logic [PASS_WIDTH-1:0]   npass;
   logic                    prime;
   logic [ROM_LATENCY:1]    vld_pipe;
   logic [CW-1:0]           inflight;
   logic [CW-1:0]           occ;
   logic [CW:0]             load;
   logic                    accept;
   logic                    issue;
   logic                    credit;
   logic                    last_word;
   logic                    fifo_push;
   logic                    fifo_pop;
   logic                    fifo_full;
   logic                    fifo_empty;

   assign accept    = (state == IDLE) && start;
   assign last_word = (addr == ADDR_WIDTH'(DEPTH - 1)) &&
                      (pass_cnt == npass - PASS_WIDTH'(1));

   // A read may be issued only if, were the consumer to stall from now on,
   // every word already in flight plus this one still fits in the FIFO. The
   // word leaving this cycle frees its slot, which keeps 1 word/cycle going.
   assign load   = {1'b0, occ} + {1'b0, inflight};
   assign credit = load < ((CW+1)'(FIFO_DEPTH) + (CW+1)'(fifo_pop));

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= IDLE;
      else      state <= state_n;
   end

   always_comb begin
      state_n = state;
      issue   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_n = (num_passes == '0) ? FIN : ISSUE;
         end
         ISSUE: begin
            // The cycle right after acceptance issues nothing; this places
            // the first word ROM_LATENCY+2 edges after the start edge.
            issue = credit && !prime;
            if (issue && last_word) state_n = DRAIN;
         end
         DRAIN: begin
            if (inflight == '0 && fifo_empty) state_n = FIN;
         end
         FIN: begin
            state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   // ---------------------------------------------------- address / passes
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         addr     <= '0;
         pass_cnt <= '0;
         npass    <= '0;
         prime    <= 1'b0;
      end else begin
         prime <= accept;
         if (accept) begin
            addr     <= '0;
            pass_cnt <= '0;
            npass    <= num_passes;
         end else if (issue) begin
            if (addr == ADDR_WIDTH'(DEPTH - 1)) begin
               addr     <= '0;
               pass_cnt <= pass_cnt + PASS_WIDTH'(1);
            end else begin
               addr <= addr + ADDR_WIDTH'(1);
            end
         end
      end
   end

   // ------------------------------------------------- in-flight tracking
   // vld_pipe[k] marks a read issued k cycles ago; the tag leaving stage
   // ROM_LATENCY lines up with its data on rom_q.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         vld_pipe <= '0;
         inflight <= '0;
      end else begin
         vld_pipe[1] <= issue;
         for (int i = 2; i <= ROM_LATENCY; i++) vld_pipe[i] <= vld_pipe[i-1];
         inflight <= inflight + CW'(issue) - CW'(vld_pipe[ROM_LATENCY]);
      end
   end

   assign fifo_push = vld_pipe[ROM_LATENCY];
   assign fifo_pop  = data_out_valid && data_out_ready;

   param_rom_skid_fifo #(
      .WIDTH (DATA_WIDTH),
      .DEPTH (FIFO_DEPTH)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (fifo_push),
      .wdata (rom_q),
      .pop   (fifo_pop),
      .rdata (data_out),
      .full  (fifo_full),
      .empty (fifo_empty),
      .count (occ)
   );

`ifndef SYNTHESIS
   overflow_chk: assert property (@(posedge clk) disable iff (!rst)
                                  !(fifo_push && fifo_full));
`endif

   // ------------------------------------------------------------ outputs
   assign busy           = (state != IDLE);
   assign done           = (state == FIN);
   assign rom_addr       = addr;
   assign rom_ce         = 1'b1;
   assign data_out_valid = !fifo_empty;

`ifdef PARAM_ROM_STREAM_CTRL_PERF_EN
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)
         stall_count <= '0;
      else if (accept)
         stall_count <= '0;
      else if (data_out_valid && !data_out_ready && stall_count != '1)
         stall_count <= stall_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_param_rom_stream_ctrl.sv
// ----------------------------------------------------------------------------
// tb_param_rom_stream_ctrl
//   Self-checking bench: ROM model with fixed latency, random/forced ready,
//   and a scoreboard that expects word n of a run to be ROM[n mod DEPTH].
// ----------------------------------------------------------------------------
module tb_param_rom_stream_ctrl;

   localparam int DW  = 16;
   localparam int DEP = 8;
   localparam int AW  = $clog2(DEP) + 1;
   localparam int LAT = 2;
   localparam int PWD = 8;

   logic           clk = 1'b0;
   logic           rst = 1'b0;
   logic           start = 1'b0;
   logic [PWD-1:0] num_passes = '0;
   logic           busy, done;
   logic [AW-1:0]  rom_addr;
   logic           rom_ce;
   logic [DW-1:0]  rom_q;
   logic [DW-1:0]  data_out;
   logic           data_out_valid;
   logic           data_out_ready;
`ifdef PARAM_ROM_STREAM_CTRL_PERF_EN
   logic [31:0]    stall_count;
`endif

   int   total = 0;
   int   bad   = 0;
   int   cyc   = 0;
   int   exp_n = 0;
   int   run_words = 0;
   int   last_pop = 0;
   int   done_cyc = -1;
   int   mode = 0;          // 0: ready=1, 1: random, 2: ready=0, 3: manual
   logic man_ready = 1'b1;
   logic rdy_gen = 1'b1;
   logic prev_stall = 1'b0;
   logic [DW-1:0] prev_data = '0;

   param_rom_stream_ctrl #(
      .DATA_WIDTH  (DW),
      .DEPTH       (DEP),
      .ADDR_WIDTH  (AW),
      .ROM_LATENCY (LAT),
      .PASS_WIDTH  (PWD)
   ) dut (
      .clk            (clk),
      .rst            (rst),
      .start          (start),
      .num_passes     (num_passes),
      .busy           (busy),
      .done           (done),
      .rom_addr       (rom_addr),
      .rom_ce         (rom_ce),
      .rom_q          (rom_q),
      .data_out       (data_out),
      .data_out_valid (data_out_valid),
      .data_out_ready (data_out_ready)
`ifdef PARAM_ROM_STREAM_CTRL_PERF_EN
      ,
      .stall_count    (stall_count)
`endif
   );

   always #5 clk = ~clk;

   function automatic logic [DW-1:0] rom_word(input int a);
      return DW'((a * 257) ^ 50010);
   endfunction

   // ROM: address seen in a cycle appears on rom_q LAT edges later.
   logic [DW-1:0] q_pipe [LAT];
   always @(posedge clk) begin
      q_pipe[0] <= rom_word(int'(rom_addr));
      for (int i = 1; i < LAT; i++) q_pipe[i] <= q_pipe[i-1];
   end
   assign rom_q = q_pipe[LAT-1];

   always @(posedge clk) cyc <= cyc + 1;

   always @(posedge clk) begin
      #1;
      case (mode)
         0: rdy_gen = 1'b1;
         1: rdy_gen = 1'($urandom_range(0, 1));
         2: rdy_gen = 1'b0;
         default: ;
      endcase
   end
   assign data_out_ready = (mode == 3) ? man_ready : rdy_gen;

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // Scoreboard / stability monitor
   always @(negedge clk) begin
      if (rst) begin
         if (prev_stall) begin
            chk("hold_vld", data_out_valid, 1);
            chk("hold_data", data_out, prev_data);
         end
         if (data_out_valid && data_out_ready) begin
            chk("in_run", exp_n < run_words, 1);
            chk("word", data_out, rom_word(exp_n % DEP));
            exp_n++;
            last_pop = cyc + 1;
         end
         if (done) done_cyc = cyc;
      end
      prev_stall = rst && data_out_valid && !data_out_ready;
      prev_data  = data_out;
   end

   task automatic do_start(input int np);
      @(posedge clk); #1;
      exp_n = 0;
      run_words = np * DEP;
      num_passes = PWD'(np);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic wait_done(input int budget);
      bit seen;
      seen = done;
      for (int k = 0; k < budget && !seen; k++) begin
         @(posedge clk); #1;
         seen = done;
      end
      chk("done_seen", seen, 1);
   endtask

   task automatic wait_words(input int n);
      for (int k = 0; k < 500 && exp_n < n; k++) begin
         @(posedge clk); #1;
      end
      chk("words_reached", exp_n >= n, 1);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      int lat, nv, a0, bufd, vsum;

      // reset state
      repeat (3) @(posedge clk);
      #1;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_valid", data_out_valid, 0);
      chk("rst_addr", rom_addr, 0);
      chk("rom_ce", rom_ce, 1);
      rst = 1'b1;
      repeat (2) @(posedge clk);

      // single pass, ready high: latency, no bubbles, done timing
      mode = 0;
      do_start(1);
      chk("busy_go", busy, 1);
      lat = 0;
      for (int k = 1; k <= 20; k++) begin
         @(posedge clk); #1;
         if (data_out_valid) begin lat = k; break; end
      end
      chk("first_lat", lat, LAT + 2);
      nv = 1;
      for (int k = 1; k < DEP; k++) begin
         @(posedge clk); #1;
         nv += int'(data_out_valid);
      end
      chk("no_bubble", nv, DEP);
      wait_done(100);
      @(negedge clk); #1;
      chk("done_edge", done_cyc, last_pop + 1);
      chk("words_a", exp_n, DEP);
      @(posedge clk); #1;
      chk("done_1cyc", done, 0);
      chk("idle_a", busy, 0);
      chk("vld_after_a", data_out_valid, 0);

      // three passes, random ready, plus a start mid-stream that must be ignored
      mode = 1;
      do_start(3);
      repeat (10) @(posedge clk);
      #1;
      num_passes = PWD'(1);
      start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      wait_done(2000);
      @(negedge clk); #1;
      chk("words_b", exp_n, 3 * DEP);
      mode = 0;

      // long stall mid-stream
      do_start(3);
      wait_words(5);
      mode = 2;
      repeat (10) @(posedge clk);
      #1;
      a0 = int'(rom_addr);
      chk("stall_vld", data_out_valid, 1);
      repeat (10) @(posedge clk);
      #1;
      chk("no_issue", rom_addr, a0);
      bufd = ((int'(rom_addr) - exp_n) % DEP + DEP) % DEP;
      chk("buffered", bufd, LAT + 1);
      mode = 0;
      wait_done(500);
      @(negedge clk); #1;
      chk("words_c", exp_n, 3 * DEP);

      // zero passes; start held into the done cycle must be ignored
      @(posedge clk); #1;
      exp_n = 0;
      run_words = 0;
      num_passes = '0;
      start = 1'b1;
      @(posedge clk); #1;
      chk("z_done", done, 1);
      chk("z_busy", busy, 1);
      @(posedge clk); #1;
      chk("z_done_off", done, 0);
      chk("z_ignored", busy, 0);
      start = 1'b0;
      vsum = 0;
      for (int k = 0; k < 6; k++) begin
         @(posedge clk); #1;
         vsum += int'(data_out_valid) + int'(rom_addr != '0) + int'(busy);
      end
      chk("z_quiet", vsum, 0);

      // reset mid-pass, then a fresh stream
      do_start(2);
      wait_words(4);
      rst = 1'b0;
      #1;
      chk("mid_rst_vld", data_out_valid, 0);
      chk("mid_rst_busy", busy, 0);
      chk("mid_rst_addr", rom_addr, 0);
      chk("mid_rst_done", done, 0);
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b1;
      repeat (4) @(posedge clk);
      #1;
      chk("post_rst_idle", busy, 0);
      chk("post_rst_vld", data_out_valid, 0);
      do_start(1);
      wait_done(200);
      @(negedge clk); #1;
      chk("words_e", exp_n, DEP);

`ifdef PARAM_ROM_STREAM_CTRL_PERF_EN
      // stall counter: exactly five stalled cycles
      mode = 3;
      man_ready = 1'b1;
      do_start(1);
      chk("perf_clr", stall_count, 0);
      for (int k = 0; k < 20 && !data_out_valid; k++) begin
         @(posedge clk); #1;
      end
      man_ready = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      man_ready = 1'b1;
      chk("stall_cnt", stall_count, 5);
      wait_done(200);
      #1;
      chk("stall_cnt_end", stall_count, 5);
      chk("words_f", exp_n, DEP);
      mode = 0;
`endif

      repeat (3) @(posedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
